// File: rtl/rgb_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : rgb_frame_sender
// Purpose  : Buffers host-written RGB pixels in a small FIFO and streams one
//            frame of IMG_W*IMG_H pixels to a downstream filter over a
//            valid/busy handshake. It pulses o_frame_done once per frame.
// Revision : 1.0 - initial release
//
// Parameters
//   FIFO_AW    FIFO address width (depth 2**FIFO_AW pixels, FIFO_AW >= 1)
//   IMG_W      pixels per line
//   IMG_H      lines per frame
//
// Ports
//   i_clk         in   1   clock, all state on rising edge
//   i_rst         in   1   asynchronous active-low reset
//   i_wr_en       in   1   host pixel write strobe
//   i_wr_data     in   24  host pixel {R,G,B}
//   o_wr_full     out  1   FIFO holds 2**FIFO_AW pixels
//   i_start       in   1   frame start pulse (accepted in IDLE only)
//   o_rgb_vld     out  1   output pixel valid
//   o_rgb_data    out  24  output pixel
//   i_rgb_busy    in   1   downstream busy; holds the output pixel
//   o_frame_done  out  1   one-cycle end-of-frame pulse
//   o_wr_ovf      out  1   sticky flag: a write arrived while full
//   o_stall_cnt   out  16  saturating busy-stall cycle count
//                          (present only with RGB_SENDER_STALL_CNT_EN)
//
// Optional feature macro: RGB_SENDER_STALL_CNT_EN
// ============================================================================
module rgb_frame_sender #(
  parameter int FIFO_AW = 2,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [23:0] i_wr_data,
  output logic        o_wr_full,
  input  logic        i_start,
  output logic        o_rgb_vld,
  output logic [23:0] o_rgb_data,
  input  logic        i_rgb_busy,
  output logic        o_frame_done,
  output logic        o_wr_ovf
`ifdef RGB_SENDER_STALL_CNT_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0]   LAST_PIX = CNT_W'(TOTAL - 1);
  localparam logic [FIFO_AW:0]   FULL_OCC = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;

  logic [23:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   occ_q;
  logic               ovf_q;

  logic               vld_q;
  logic [23:0]        data_q;

  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;   // completed transfers
  logic [CNT_W-1:0]   ld_cnt_q, ld_cnt_d;     // pixels loaded into output reg
  logic               all_ld_q, all_ld_d;     // whole frame already loaded

  logic               w_full, w_empty, w_push, w_load, w_xfer;

  // --------------------------------------------------------------------------
  // Handshake and FIFO control
  // --------------------------------------------------------------------------
  assign w_full  = (occ_q == FULL_OCC);
  assign w_empty = (occ_q == '0);
  // Fullness comes from registered occupancy only, so a write on the same
  // edge as a pop from a full FIFO is still dropped.
  assign w_push  = i_wr_en & ~w_full;
  assign w_xfer  = vld_q & ~i_rgb_busy;
  // Refill the output register when it is empty or emptying this edge, but
  // never beyond the last pixel of the frame: leftovers stay queued.
  assign w_load  = (state_q == SEND) & ~w_empty & (~vld_q | w_xfer) & ~all_ld_q;

  // --------------------------------------------------------------------------
  // Frame FSM: next state and counters
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    ld_cnt_d     = ld_cnt_q;
    all_ld_d     = all_ld_q;
    o_frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = SEND;
          pix_cnt_d = '0;
          ld_cnt_d  = '0;
          all_ld_d  = 1'b0;
        end
      end
      SEND: begin
        if (w_load) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST_PIX) begin
            all_ld_d = 1'b1;
          end
        end
        if (w_xfer) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        o_frame_done = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      ld_cnt_q  <= '0;
      all_ld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      all_ld_q  <= all_ld_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (data array needs no reset; pointers/occupancy qualify it)
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_load})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (i_wr_en && w_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (w_load) begin
      vld_q  <= 1'b1;
      data_q <= mem_q[rd_ptr_q];
    end else if (w_xfer) begin
      vld_q  <= 1'b0;
    end
  end

  assign o_wr_full  = w_full;
  assign o_wr_ovf   = ovf_q;
  assign o_rgb_vld  = vld_q;
  assign o_rgb_data = data_q;

`ifdef RGB_SENDER_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Stall counter: cycles a valid pixel is held off by busy, saturating
  // --------------------------------------------------------------------------
  logic [15:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && i_start) begin
      stall_q <= '0;
    end else if (vld_q && i_rgb_busy && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_frame_sender
// Purpose  : Self-checking bench for rgb_frame_sender with a 2x2 frame and a
//            4-deep FIFO. A pixel scoreboard (queue in write order) supplies
//            the expected data of every transfer; frame length, done pulse,
//            latency, fullness and overflow are checked from directed steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_frame_sender;

  localparam int FIFO_AW = 2;
  localparam int IMG_W   = 2;
  localparam int IMG_H   = 2;
  localparam int FRAME   = IMG_W * IMG_H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [23:0] i_wr_data = 24'h0;
  logic        i_start = 1'b0;
  logic        i_rgb_busy = 1'b0;
  logic        o_wr_full, o_rgb_vld, o_frame_done, o_wr_ovf;
  logic [23:0] o_rgb_data;
`ifdef RGB_SENDER_STALL_CNT_EN
  logic [15:0] o_stall_cnt;
`endif

  rgb_frame_sender #(.FIFO_AW(FIFO_AW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_en      (i_wr_en),
    .i_wr_data    (i_wr_data),
    .o_wr_full    (o_wr_full),
    .i_start      (i_start),
    .o_rgb_vld    (o_rgb_vld),
    .o_rgb_data   (o_rgb_data),
    .i_rgb_busy   (i_rgb_busy),
    .o_frame_done (o_frame_done),
    .o_wr_ovf     (o_wr_ovf)
`ifdef RGB_SENDER_STALL_CNT_EN
    ,
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          nxfer   = 0;
  int          ndone   = 0;
  int          cyc     = 0;
  bit          wr_accept = 1'b1;
  logic [23:0] exp_q[$];
  int          xcyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Entered 1ns after a rising edge; samples mid-cycle,
  // records accepted writes and completed transfers, returns 1ns after the
  // next rising edge.
  task automatic cycle();
    logic [23:0] e;
    #4;
    if (i_wr_en && wr_accept) exp_q.push_back(i_wr_data);
    if (o_rgb_vld && !i_rgb_busy) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 24'hxxxxxx;
      check("xfer_data", {8'h0, o_rgb_data}, {8'h0, e});
      nxfer++;
      xcyc.push_back(cyc);
    end
    if (o_frame_done) ndone++;
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_px(input logic [23:0] d);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    cycle();
    i_wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_wr_en = 1'b0; i_start = 1'b0; i_rgb_busy = 1'b0;
    #1;
    check("rst_vld",  o_rgb_vld,    0);
    check("rst_data", o_rgb_data,   0);
    check("rst_full", o_wr_full,    0);
    check("rst_done", o_frame_done, 0);
    check("rst_ovf",  o_wr_ovf,     0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
  endtask

  // Runs (optionally starts) a frame and waits for FRAME transfers, then
  // checks the done pulse timing.
  task automatic run_frame(input int busy_pct, input int restart_at,
                           input int extra_wr, input bit do_start);
    int sx, d0, to, ex;
    bit rs;
    sx = nxfer; d0 = ndone; ex = extra_wr; rs = 1'b0; to = 0;
    if (do_start) begin
      i_start    = 1'b1;
      i_rgb_busy = (int'($urandom_range(99)) < busy_pct);
      cycle();
      i_start = 1'b0;
    end
    while ((nxfer - sx) < FRAME && to < 400) begin
      i_rgb_busy = (int'($urandom_range(99)) < busy_pct);
      if (!rs && restart_at >= 0 && (nxfer - sx) == restart_at) begin
        i_start = 1'b1;
        rs      = 1'b1;
      end
      if (ex > 0 && !o_wr_full) begin
        i_wr_en   = 1'b1;
        i_wr_data = 24'($urandom);
        ex--;
      end
      cycle();
      i_start = 1'b0;
      i_wr_en = 1'b0;
      to++;
    end
    check("frame_xfers", nxfer - sx, FRAME);
    i_rgb_busy = 1'b0;
    check("done_pulse", o_frame_done, 1);
    check("vld_after_last", o_rgb_vld, 0);
    cycle();
    check("done_one_cycle", o_frame_done, 0);
    check("done_count", ndone - d0, 1);
    if (busy_pct == 0 && xcyc.size() >= FRAME)
      check("back_to_back", xcyc[xcyc.size()-1] - xcyc[xcyc.size()-FRAME], FRAME - 1);
  endtask

  initial begin
    int to;
    @(posedge i_clk);
    #1;
    // Reset state
    do_reset();

    // Four pixels then start, busy low: consecutive transfers and done pulse
    for (int i = 0; i < FRAME; i++) write_px(24'($urandom));
    check("full_after_4", o_wr_full, 1);
    run_frame(0, -1, 0, 1'b1);

    // One-cycle latency from write into an empty FIFO while sending
    i_rgb_busy = 1'b1;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    cycle();
    check("send_empty_vld", o_rgb_vld, 0);
    begin
      logic [23:0] d;
      d = 24'($urandom);
      write_px(d);
      check("lat_edge_n_vld", o_rgb_vld, 0);
      cycle();
      check("lat_edge_n1_vld", o_rgb_vld, 1);
      check("lat_edge_n1_data", {8'h0, o_rgb_data}, {8'h0, d});
    end
    for (int i = 1; i < FRAME; i++) write_px(24'($urandom));
    run_frame(0, -1, 0, 1'b0);

    // Busy held for five cycles on a valid pixel
    write_px(24'h123456);
    for (int i = 1; i < FRAME; i++) write_px(24'($urandom));
    i_rgb_busy = 1'b1;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    to = 0;
    while (!o_rgb_vld && to < 10) begin
      cycle();
      to++;
    end
    check("stall_vld_seen", o_rgb_vld, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_vld", o_rgb_vld, 1);
      check("stall_hold_data", {8'h0, o_rgb_data}, 32'h00123456);
      cycle();
    end
`ifdef RGB_SENDER_STALL_CNT_EN
    check("stall_cnt", o_stall_cnt, 5);
`endif
    check("stall_pending_data", {8'h0, o_rgb_data}, 32'h00123456);
    run_frame(0, -1, 0, 1'b0);

    // Start re-asserted mid-frame is ignored
    for (int i = 0; i < FRAME; i++) write_px(24'($urandom));
    run_frame(0, 2, 0, 1'b1);

    // Six pixels queued for a four-pixel frame: two carry over
    for (int i = 0; i < FRAME; i++) write_px(24'($urandom));
    run_frame(0, -1, 2, 1'b1);
    check("carry_queue_len", exp_q.size(), 2);
    for (int i = 0; i < 2; i++) write_px(24'($urandom));
    check("idle_no_load_vld", o_rgb_vld, 0);
    check("idle_full_carry", o_wr_full, 1);
    run_frame(0, -1, 0, 1'b1);

    // Overflow: five writes with no start
    check("ovf_clear_before", o_wr_ovf, 0);
    for (int i = 0; i < FRAME; i++) begin
      write_px(24'($urandom));
      check("full_progress", o_wr_full, (i == FRAME - 1) ? 1 : 0);
    end
    check("ovf_before_5th", o_wr_ovf, 0);
    wr_accept = 1'b0;
    write_px(24'hDEAD01);
    wr_accept = 1'b1;
    check("ovf_set", o_wr_ovf, 1);
    check("full_after_drop", o_wr_full, 1);
    run_frame(0, -1, 0, 1'b1);
    check("ovf_sticky", o_wr_ovf, 1);

    // Reset mid-frame after two transfers
    for (int i = 0; i < FRAME; i++) write_px(24'($urandom));
    begin
      int sx;
      sx = nxfer;
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      to = 0;
      while ((nxfer - sx) < 2 && to < 20) begin
        cycle();
        to++;
      end
      check("pre_reset_xfers", nxfer - sx, 2);
    end
    do_reset();
    for (int i = 0; i < FRAME; i++) write_px(24'($urandom));
    check("post_reset_full", o_wr_full, 1);
    run_frame(0, -1, 0, 1'b1);

    // Randomized frames with random backpressure
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < FRAME; i++) write_px(24'($urandom));
      run_frame(40, -1, 0, 1'b1);
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_frame_sender.md
RGB_FRAME_SENDER -- requirements
Module: rgb_frame_sender

Interface
REQ-001 SHALL provide parameter FIFO_AW, default 2, FIFO address width (depth 2^FIFO_AW pixels).
REQ-002 SHALL provide parameter IMG_W, default 256, pixels per line.
REQ-003 SHALL provide parameter IMG_H, default 256, lines per frame.
REQ-004 SHALL have port i_clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_wr_en  in  1  host pixel write strobe.
REQ-007 SHALL have port i_wr_data  in  24  host pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 SHALL have port o_wr_full  out  1  FIFO full; combinational from occupancy.
REQ-009 SHALL have port i_start  in  1  frame start pulse.
REQ-010 SHALL have port o_rgb_vld  out  1  output pixel valid.
REQ-011 SHALL have port o_rgb_data  out  24  output pixel.
REQ-012 SHALL have port i_rgb_busy  in  1  downstream filter busy.
REQ-013 SHALL have port o_frame_done  out  1  one-cycle end-of-frame pulse.
REQ-014 SHALL have port o_wr_ovf  out  1  sticky overflow flag.

Function
REQ-015 SHALL complete a transfer on a rising edge where o_rgb_vld=1 and i_rgb_busy=0.
REQ-016 SHALL hold o_rgb_vld and o_rgb_data stable while o_rgb_vld=1 and i_rgb_busy=1.
REQ-017 SHALL push i_wr_data when i_wr_en=1 and FIFO not full; a write while full is dropped and sets o_wr_ovf.
REQ-018 SHALL drive o_wr_full=1 exactly when occupancy = 2^FIFO_AW, including a cycle where the output register pops.
REQ-019 SHALL use FSM states IDLE, SEND, DONE; reset state IDLE.
REQ-020 SHALL move IDLE->SEND on i_start=1 and clear the pixel counter; i_start in SEND or DONE is ignored.
REQ-021 SHALL, in SEND, load the output register from the FIFO head on an edge where the FIFO is non-empty and the register is empty or transferring; back-to-back loads sustain one pixel per cycle.
REQ-022 SHALL give a latency of 1 cycle: a pixel written at edge N into an empty FIFO with an empty output register in SEND shows o_rgb_vld=1 after edge N+1.
REQ-023 SHALL count transfers with a counter of width clog2(IMG_W*IMG_H); the transfer at count IMG_W*IMG_H-1 moves SEND->DONE.
REQ-024 SHALL issue no further load after the final frame pixel is loaded; remaining FIFO data waits for the next frame.
REQ-025 SHALL assert o_frame_done for exactly the one cycle spent in DONE, then go DONE->IDLE.
REQ-026 SHALL keep accepting FIFO writes in IDLE and DONE without loading the output register.

Reset
REQ-027 SHALL, while i_rst=0, clear FIFO pointers and occupancy, pixel counter, output register and stall counter, and enter IDLE.
REQ-028 SHALL drive o_rgb_vld=0, o_rgb_data=0, o_wr_full=0, o_frame_done=0 and o_wr_ovf=0 during reset.
REQ-029 SHALL discard an in-flight frame when reset asserts mid-SEND; after release the FIFO is empty and the state is IDLE.

Configuration
REQ-030 SHALL, with macro RGB_SENDER_STALL_CNT_EN defined, add output o_stall_cnt[15:0]: it increments each cycle with o_rgb_vld=1 and i_rgb_busy=1, saturates at 16'hFFFF, and clears on i_start acceptance.
REQ-031 SHALL, without RGB_SENDER_STALL_CNT_EN, omit port o_stall_cnt and its logic entirely; all other behaviour is identical.

Verification
REQ-032 SHALL cover IMG_W=2, IMG_H=2: write 4 pixels, start, busy=0 -> 4 transfers on consecutive cycles, then o_frame_done pulse.
REQ-033 SHALL cover holding i_rgb_busy=1 for 5 cycles while pixel 24'h123456 is valid -> data held steady, transferred on the first edge with busy=0; o_stall_cnt=5 if enabled.
REQ-034 SHALL cover FIFO_AW=2 with 5 writes and no start -> o_wr_full=1 after 4 writes, 5th dropped, o_wr_ovf=1.
REQ-035 SHALL cover i_rst asserted mid-frame after 2 of 4 transfers -> o_rgb_vld=0 immediately, IDLE, and a new start with 4 writes gives a full 4-pixel frame.
REQ-036 SHALL cover i_start re-asserted during SEND -> ignored, and the pixel count is unaffected.
REQ-037 SHALL cover 6 pixels queued with a 4-pixel frame -> 4 sent, done pulse, 2 remain queued and are sent first in the next frame.
